// File: rtl/vblank_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vblank_write_scheduler
// Purpose  : Queues Avalon-MM writes and replays them into addr_decode only
//            during vertical blanking, one commit per cycle in FIFO order.
// Revision : 1.0 - initial release
// ============================================================================
module vblank_write_scheduler #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          avs_chipselect,
  input  logic          avs_write,
  input  logic [11:0]   avs_address,
  input  logic [31:0]   avs_writedata,
  output logic          avs_waitrequest,
  input  logic          vblank,
  output logic [11:0]   dec_addr,
  output logic [31:0]   dec_write_data,
  output logic          dec_chip_select,
  output logic          dec_write,
  output logic [CW-1:0] fifo_count,
  output logic          frame_done,
  output logic          backlog
);

  localparam int            C_AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [43:0]       r_mem [DEPTH];
  logic [C_AW-1:0]   r_wr_ptr;
  logic [C_AW-1:0]   r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_vb_q;
  logic [11:0]       r_dec_addr;
  logic [31:0]       r_dec_data;
  logic              r_dec_we;
  logic              r_frame_done;
  logic              r_backlog;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Full is taken from the registered count, so a pop in the same cycle
  // does not release the stall until the next cycle.
  assign w_full          = (r_count == C_FULL);
  assign w_empty         = (r_count == '0);
  assign w_push          = avs_chipselect & avs_write & ~w_full;
  assign w_pop           = (r_state == S_DRAIN) & r_vb_q & ~w_empty;
  assign avs_waitrequest = avs_chipselect & avs_write & w_full;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_vb_q) w_next = S_DRAIN;
      S_DRAIN: begin
        if (!r_vb_q)      w_next = S_IDLE;
        else if (w_empty) w_next = S_DONE;
      end
      S_DONE:  if (!r_vb_q) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {avs_address, avs_writedata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_vb_q       <= 1'b0;
      r_dec_addr   <= '0;
      r_dec_data   <= '0;
      r_dec_we     <= 1'b0;
      r_frame_done <= 1'b0;
      r_backlog    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vb_q  <= vblank;
      if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Decoder address/data hold their last committed value between commits.
      r_dec_we <= w_pop;
      if (w_pop) {r_dec_addr, r_dec_data} <= r_mem[r_rd_ptr];
      r_frame_done <= (r_state == S_DRAIN) & r_vb_q & w_empty;
      if ((r_state == S_DRAIN) && !r_vb_q && !w_empty) r_backlog <= 1'b1;
    end
  end

  assign dec_addr        = r_dec_addr;
  assign dec_write_data  = r_dec_data;
  assign dec_chip_select = r_dec_we;
  assign dec_write       = r_dec_we;
  assign fifo_count      = r_count;
  assign frame_done      = r_frame_done;
  assign backlog         = r_backlog;

endmodule
`default_nettype wire

// File: tb/tb_vblank_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vblank_write_scheduler
// Purpose  : Randomized bench comparing the scheduler against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vblank_write_scheduler;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          avs_chipselect = 1'b0;
  logic          avs_write = 1'b0;
  logic [11:0]   avs_address = '0;
  logic [31:0]   avs_writedata = '0;
  logic          vblank = 1'b1;
  logic          avs_waitrequest;
  logic [11:0]   dec_addr;
  logic [31:0]   dec_write_data;
  logic          dec_chip_select;
  logic          dec_write;
  logic [CW-1:0] fifo_count;
  logic          frame_done;
  logic          backlog;

  vblank_write_scheduler #(.DEPTH(DEPTH), .CW(CW)) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_chipselect  (avs_chipselect),
    .avs_write       (avs_write),
    .avs_address     (avs_address),
    .avs_writedata   (avs_writedata),
    .avs_waitrequest (avs_waitrequest),
    .vblank          (vblank),
    .dec_addr        (dec_addr),
    .dec_write_data  (dec_write_data),
    .dec_chip_select (dec_chip_select),
    .dec_write       (dec_write),
    .fifo_count      (fifo_count),
    .frame_done      (frame_done),
    .backlog         (backlog)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: a queue of pending writes plus the blanking window's phase
  // (0 = waiting for blanking, 1 = draining, 2 = drained, waiting for end).
  logic [43:0] mq[$];
  bit          m_vbq;
  int          m_phase;
  logic [11:0] e_addr;
  logic [31:0] e_data;
  bit          e_dw, e_fd, e_bl;

  task automatic model_reset();
    mq.delete();
    m_vbq = 0; m_phase = 0;
    e_addr = '0; e_data = '0; e_dw = 0; e_fd = 0; e_bl = 0;
  endtask

  task automatic model_edge();
    int n;
    bit pop, push;
    n    = mq.size();
    push = avs_chipselect && avs_write && (n != DEPTH);
    pop  = (m_phase == 1) && m_vbq && (n != 0);
    e_dw = pop;
    e_fd = (m_phase == 1) && m_vbq && (n == 0);
    if (pop) {e_addr, e_data} = mq.pop_front();
    if ((m_phase == 1) && !m_vbq && (n != 0)) e_bl = 1;
    if (!m_vbq)                          m_phase = 0;
    else if (m_phase == 0)               m_phase = 1;
    else if ((m_phase == 1) && (n == 0)) m_phase = 2;
    if (push) mq.push_back({avs_address, avs_writedata});
    m_vbq = vblank;
  endtask

  task automatic check_outputs();
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
    check("dec_write", 64'(dec_write), 64'(e_dw));
    check("dec_chip_select", 64'(dec_chip_select), 64'(e_dw));
    check("dec_addr", 64'(dec_addr), 64'(e_addr));
    check("dec_write_data", 64'(dec_write_data), 64'(e_data));
    check("frame_done", 64'(frame_done), 64'(e_fd));
    check("backlog", 64'(backlog), 64'(e_bl));
    check("waitrequest", 64'(avs_waitrequest),
          64'(avs_chipselect && avs_write && (mq.size() == DEPTH)));
  endtask

  // Called just after a falling edge: drive, check, then advance the model
  // across the next rising edge. Reports whether this request was stalled.
  task automatic drive_and_check(input bit c, input bit w, input logic [11:0] a,
                                 input logic [31:0] d, input bit v, output bit stalled);
    avs_chipselect = c; avs_write = w; avs_address = a; avs_writedata = d; vblank = v;
    #1;
    check_outputs();
    stalled = c && w && (mq.size() == DEPTH);
    model_edge();
  endtask

  task automatic step(input bit c, input bit w, input logic [11:0] a,
                      input logic [31:0] d, input bit v, output bit stalled);
    @(negedge clk);
    drive_and_check(c, w, a, d, v, stalled);
  endtask

  initial begin
    bit          c, w, vb, hold, stalled, did_rst;
    logic [11:0] a;
    logic [31:0] d;
    int          run;

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs();

    // Release with vblank low, queue one write, then exercise select gating.
    @(negedge clk);
    reset_n = 1'b1;
    drive_and_check(1'b1, 1'b1, 12'h0A5, 32'hAAAA_AAAA, 1'b0, stalled);
    step(1'b0, 1'b1, 12'h111, 32'h1111_1111, 1'b0, stalled);
    step(1'b1, 1'b0, 12'h222, 32'h2222_2222, 1'b0, stalled);
    step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, stalled);

    vb = 0; run = 0; hold = 0; did_rst = 0;
    c = 0; w = 0; a = '0; d = '0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        vb  = !vb;
        run = vb ? int'($urandom_range(1, 24)) : int'($urandom_range(3, 40));
      end
      run--;
      if (!hold) begin
        c = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 3) != 0);
        a = 12'($urandom);
        d = $urandom;
      end
      if (!did_rst && (i > 2000) && (m_phase == 1) && m_vbq && (mq.size() > 1)) begin
        // Asynchronous reset landing between clock edges.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        drive_and_check(1'b0, 1'b0, 12'h000, 32'h0, vb, stalled);
        hold = 0;
        did_rst = 1;
      end else begin
        step(c, w, a, d, vb, stalled);
        hold = stalled;
      end
    end
    check("async_reset_reached", 64'(did_rst), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
